bus_page_ctl: RTL and testbench

Parametrised CPU-bus front end for the FPGA memory map. Decodes `BRAM_SELECT` into one-hot target enables and hosts a bank of `NUM_PAGE` page registers written through the controller BRAM window. Adds per-page lock/pending handling, update strobes and registered readback. It sits between the CPU bus pins (tri-state handled at top level) and the modulator/STM/normal memory writers, which consume the enables and page numbers.

---
 rtl/bus_page_pkg.sv | 24 ++
 rtl/bus_page_slot.sv | 78 +++++++
 rtl/bus_page_ctl.sv | 109 ++++++++++
 tb/tb_bus_page_ctl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_page_pkg.sv
// Shared encodings for the CPU-bus front end: target selects, controller
// window addresses and the per-page slot action used by the page registers.
package bus_page_pkg;

    localparam logic [1:0] BRAM_SELECT_CONTROLLER = 2'd0;
    localparam logic [1:0] BRAM_SELECT_NORMAL     = 2'd1;
    localparam logic [1:0] BRAM_SELECT_STM        = 2'd2;
    localparam logic [1:0] BRAM_SELECT_MOD        = 2'd3;

    localparam logic [13:0] ADDR_PEND      = 14'h001F;
    localparam logic [13:0] ADDR_PAGE_BASE = 14'h0020;

    localparam logic [13:0] PAGE_BASE_DEFAULT = ADDR_PAGE_BASE;
    localparam logic [13:0] PEND_ADDR_DEFAULT = ADDR_PEND;

    // What a page slot does at a given edge.
    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_LOAD,
        SLOT_DEFER,
        SLOT_APPLY
    } slot_act_e;

endpackage

// File: rtl/bus_page_slot.sv
// One page register with lock-aware deferral: locked writes park in a pending
// buffer and are applied on the first edge the consumer releases the lock.
module bus_page_slot
    import bus_page_pkg::*;
#(
    parameter int PAGE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_i,
    input  logic [PAGE_W-1:0] wdata_i,
    input  logic              lock_i,
    output logic [PAGE_W-1:0] page_o,
    output logic              pend_o,
    output logic              update_o,
    output slot_act_e         act_o
);

    logic [PAGE_W-1:0] page_q, page_d;
    logic [PAGE_W-1:0] pdata_q, pdata_d;
    logic              pend_q, pend_d;
    logic              upd_q, upd_d;
    slot_act_e         act;

    // A fresh commit always beats a deferred apply on the same edge.
    always_comb begin
        act = SLOT_HOLD;
        if (commit_i) begin
            act = lock_i ? SLOT_DEFER : SLOT_LOAD;
        end else if (pend_q && !lock_i) begin
            act = SLOT_APPLY;
        end
    end

    always_comb begin
        page_d  = page_q;
        pdata_d = pdata_q;
        pend_d  = pend_q;
        upd_d   = 1'b0;
        case (act)
            SLOT_LOAD: begin
                page_d = wdata_i;
                pend_d = 1'b0;
                upd_d  = 1'b1;
            end
            SLOT_DEFER: begin
                pdata_d = wdata_i;
                pend_d  = 1'b1;
            end
            SLOT_APPLY: begin
                page_d = pdata_q;
                pend_d = 1'b0;
                upd_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q  <= '0;
            pdata_q <= '0;
            pend_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            page_q  <= page_d;
            pdata_q <= pdata_d;
            pend_q  <= pend_d;
            upd_q   <= upd_d;
        end
    end

    assign page_o   = page_q;
    assign pend_o   = pend_q;
    assign update_o = upd_q;
    assign act_o    = act;

endmodule

// File: rtl/bus_page_ctl.sv
// CPU-bus front end: one-hot target decode, WE edge detection, a bank of
// lockable page registers and the registered controller readback.
module bus_page_ctl
    import bus_page_pkg::*;
#(
    parameter int                SEL_W     = 2,
    parameter int                CTL_SEL   = 0,
    parameter int                ADDR_W    = 14,
    parameter int                DATA_W    = 16,
    parameter int                NUM_PAGE  = 4,
    parameter int                PAGE_W    = 5,
    parameter logic [ADDR_W-1:0] PAGE_BASE = ADDR_W'(PAGE_BASE_DEFAULT),
    parameter logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(PEND_ADDR_DEFAULT)
) (
    input  logic                       BUS_CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       RD,
    input  logic                       WE,
    input  logic [SEL_W-1:0]           BRAM_SELECT,
    input  logic [ADDR_W-1:0]          BRAM_ADDR,
    input  logic [DATA_W-1:0]          DATA_IN,
    output logic [(2**SEL_W)-1:0]      TGT_EN,
    input  logic [NUM_PAGE-1:0]        PAGE_LOCK,
    output logic [NUM_PAGE*PAGE_W-1:0] PAGE,
    output logic [NUM_PAGE-1:0]        PAGE_UPDATE,
    output logic [NUM_PAGE-1:0]        PEND,
    output logic [DATA_W-1:0]          CTL_DATA_OUT
);

    localparam int NUM_SEL = 2**SEL_W;

    logic [2:0]          we_sh_q, we_sh_d;
    logic                ctl_en;
    logic                commit;
    logic [NUM_PAGE-1:0] page_hit;
    logic [NUM_PAGE-1:0] slot_commit;
    logic [DATA_W-1:0]   ctl_data_q, ctl_data_d;
    slot_act_e           slot_act [NUM_PAGE];
    logic                unused_data;

    assign unused_data = ^DATA_IN;

    always_comb begin
        TGT_EN = '0;
        for (int s = 0; s < NUM_SEL; s++) begin
            TGT_EN[s] = EN && (BRAM_SELECT == SEL_W'(s));
        end
    end

    assign ctl_en = TGT_EN[CTL_SEL];

    // WE is asynchronous; the shift register doubles as synchroniser, and
    // 011 marks the second sampled-high edge, giving one commit per pulse.
    assign we_sh_d = {we_sh_q[1:0], WE & ctl_en};
    assign commit  = (we_sh_q == 3'b011);

    always_comb begin
        for (int i = 0; i < NUM_PAGE; i++) begin
            page_hit[i] = (BRAM_ADDR == PAGE_BASE + ADDR_W'(i));
        end
    end

    assign slot_commit = commit ? page_hit : '0;

    for (genvar g = 0; g < NUM_PAGE; g++) begin : g_slot
        bus_page_slot #(
            .PAGE_W (PAGE_W)
        ) u_slot (
            .clk      (BUS_CLK),
            .rst      (RST),
            .commit_i (slot_commit[g]),
            .wdata_i  (DATA_IN[PAGE_W-1:0]),
            .lock_i   (PAGE_LOCK[g]),
            .page_o   (PAGE[g*PAGE_W +: PAGE_W]),
            .pend_o   (PEND[g]),
            .update_o (PAGE_UPDATE[g]),
            .act_o    (slot_act[g])
        );
    end

    always_comb begin
        ctl_data_d = ctl_data_q;
        if (ctl_en && RD) begin
            ctl_data_d = '0;
            if (BRAM_ADDR == PEND_ADDR) begin
                ctl_data_d = DATA_W'(PEND);
            end
            for (int i = 0; i < NUM_PAGE; i++) begin
                if (page_hit[i]) begin
                    ctl_data_d = DATA_W'(PAGE[i*PAGE_W +: PAGE_W]);
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            we_sh_q    <= 3'b000;
            ctl_data_q <= '0;
        end else begin
            we_sh_q    <= we_sh_d;
            ctl_data_q <= ctl_data_d;
        end
    end

    assign CTL_DATA_OUT = ctl_data_q;

endmodule

// File: tb/tb_bus_page_ctl.sv
// Directed bench for bus_page_ctl: page writes, lock deferral, WE filtering,
// readback and reset abort, checked with immediate assertions.
module tb_bus_page_ctl;

    logic        BUS_CLK;
    logic        RST;
    logic        EN;
    logic        RD;
    logic        WE;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] BRAM_ADDR;
    logic [15:0] DATA_IN;
    logic [3:0]  TGT_EN;
    logic [3:0]  PAGE_LOCK;
    logic [19:0] PAGE;
    logic [3:0]  PAGE_UPDATE;
    logic [3:0]  PEND;
    logic [15:0] CTL_DATA_OUT;

    int n_assert = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int snap;

    bus_page_ctl dut (
        .BUS_CLK      (BUS_CLK),
        .RST          (RST),
        .EN           (EN),
        .RD           (RD),
        .WE           (WE),
        .BRAM_SELECT  (BRAM_SELECT),
        .BRAM_ADDR    (BRAM_ADDR),
        .DATA_IN      (DATA_IN),
        .TGT_EN       (TGT_EN),
        .PAGE_LOCK    (PAGE_LOCK),
        .PAGE         (PAGE),
        .PAGE_UPDATE  (PAGE_UPDATE),
        .PEND         (PEND),
        .CTL_DATA_OUT (CTL_DATA_OUT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    always @(negedge BUS_CLK) begin
        upd_cnt = upd_cnt + $countones(PAGE_UPDATE);
    end

    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One idle edge, then WE held across edges k, k+1, k+2; returns after k+2.
    task automatic ctl_write(input logic [13:0] addr, input logic [15:0] data);
        WE = 1'b0;
        step();
        EN          = 1'b1;
        BRAM_SELECT = 2'd0;
        BRAM_ADDR   = addr;
        DATA_IN     = data;
        WE          = 1'b1;
        step();
        step();
        step();
        WE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; RD = 1'b0; WE = 1'b0;
        BRAM_SELECT = 2'd0; BRAM_ADDR = '0; DATA_IN = '0; PAGE_LOCK = '0;
        step();
        step();
        check("rst_page", PAGE, 20'h0);
        check("rst_pend", PEND, 4'h0);
        check("rst_upd", PAGE_UPDATE, 4'h0);
        check("rst_rdata", CTL_DATA_OUT, 16'h0);
        RST = 1'b0;
        step();

        EN = 1'b1; BRAM_SELECT = 2'd3; #1;
        check("tgt_mod", TGT_EN, 4'b1000);
        BRAM_SELECT = 2'd0; #1;
        check("tgt_ctl", TGT_EN, 4'b0001);
        EN = 1'b0; #1;
        check("tgt_off", TGT_EN, 4'b0000);

        ctl_write(14'h0021, 16'h0013);
        check("w1_page", PAGE, 20'h00260);
        check("w1_upd", PAGE_UPDATE, 4'b0010);
        step();
        check("w1_upd_end", PAGE_UPDATE, 4'b0000);

        PAGE_LOCK = 4'b0100;
        snap = upd_cnt;
        ctl_write(14'h0022, 16'h0007);
        check("lk_page_a", PAGE, 20'h00260);
        check("lk_pend_a", PEND, 4'b0100);
        ctl_write(14'h0022, 16'h0009);
        check("lk_page_b", PAGE, 20'h00260);
        check("lk_pend_b", PEND, 4'b0100);
        step();
        check("lk_no_pulse", upd_cnt, snap);
        PAGE_LOCK = 4'b0000;
        step();
        check("unlk_page", PAGE, 20'h02660);
        check("unlk_upd", PAGE_UPDATE, 4'b0100);
        check("unlk_pend", PEND, 4'b0000);
        step();
        check("unlk_upd_end", PAGE_UPDATE, 4'b0000);

        PAGE_LOCK = 4'b0001;
        ctl_write(14'h0020, 16'h0003);
        check("same_pend0", PEND, 4'b0001);
        WE = 1'b0;
        step();
        BRAM_ADDR = 14'h0020; DATA_IN = 16'h001A; WE = 1'b1;
        step();
        step();
        PAGE_LOCK = 4'b0000;
        snap = upd_cnt;
        step();
        WE = 1'b0;
        check("same_page", PAGE, 20'h0267A);
        check("same_upd", PAGE_UPDATE, 4'b0001);
        check("same_pend", PEND, 4'b0000);
        step();
        step();
        check("same_one_pulse", upd_cnt - snap, 1);
        check("same_page_keep", PAGE, 20'h0267A);

        snap = upd_cnt;
        step();
        BRAM_ADDR = 14'h0023; DATA_IN = 16'h0011; WE = 1'b1;
        step();
        WE = 1'b0;
        step();
        step();
        step();
        check("glitch_page", PAGE, 20'h0267A);
        check("glitch_cnt", upd_cnt - snap, 0);
        DATA_IN = 16'h001F; WE = 1'b1;
        for (int i = 0; i < 10; i++) step();
        WE = 1'b0;
        step();
        step();
        check("held_page", PAGE, 20'hFA67A);
        check("held_cnt", upd_cnt - snap, 1);
        snap = upd_cnt;
        ctl_write(14'h0024, 16'h0005);
        step();
        step();
        check("oor_page", PAGE, 20'hFA67A);
        check("oor_cnt", upd_cnt - snap, 0);

        PAGE_LOCK = 4'b1001;
        ctl_write(14'h0020, 16'h0004);
        ctl_write(14'h0023, 16'h0002);
        step();
        check("rb_pend", PEND, 4'b1001);
        EN = 1'b1; BRAM_SELECT = 2'd0; RD = 1'b1; BRAM_ADDR = 14'h001F;
        step();
        check("rb_pendword", CTL_DATA_OUT, 16'h0009);
        BRAM_ADDR = 14'h0023;
        step();
        check("rb_page3", CTL_DATA_OUT, 16'h001F);
        BRAM_SELECT = 2'd3; BRAM_ADDR = 14'h001F;
        step();
        check("rb_hold", CTL_DATA_OUT, 16'h001F);
        BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0100;
        step();
        check("rb_other", CTL_DATA_OUT, 16'h0000);
        BRAM_ADDR = 14'h0021;
        step();
        check("rb_page1", CTL_DATA_OUT, 16'h0013);
        RD = 1'b0;
        PAGE_LOCK = 4'b0000;
        snap = upd_cnt;
        step();
        check("rb_apply_page", PAGE, 20'h12664);
        check("rb_apply_upd", PAGE_UPDATE, 4'b1001);
        step();
        check("rb_apply_cnt", upd_cnt - snap, 2);

        WE = 1'b0;
        step();
        BRAM_ADDR = 14'h0021; DATA_IN = 16'h000A; WE = 1'b1;
        step();
        RST = 1'b1; WE = 1'b0;
        #1;
        check("mid_rst_page", PAGE, 20'h0);
        check("mid_rst_pend", PEND, 4'h0);
        check("mid_rst_upd", PAGE_UPDATE, 4'h0);
        check("mid_rst_rdata", CTL_DATA_OUT, 16'h0);
        step();
        RST = 1'b0;
        snap = upd_cnt;
        for (int i = 0; i < 5; i++) step();
        check("post_rst_cnt", upd_cnt - snap, 0);
        check("post_rst_page", PAGE, 20'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
